// File: rtl/regfile_banked.sv
// Banked register file: even and odd registers live in separate single-write RAMs,
// so any adjacent pair (including odd-aligned and wrap-around) is one access per bank.
module regfile_banked #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned NUM_REGS       = 32,
  parameter int unsigned CLEAR_ON_RESET = 1,
  localparam int unsigned AW            = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 ready,
  input  logic [AW-1:0]        a,
  input  logic                 a_word,
  output logic [2*WIDTH-1:0]   Ra,
  input  logic [AW-1:0]        b,
  output logic [WIDTH-1:0]     Rb,
  input  logic                 write,
  input  logic                 write_word,
  input  logic [AW-1:0]        d,
  input  logic [2*WIDTH-1:0]   Rd
);

  localparam int unsigned HALF = NUM_REGS / 2;

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t              state_q, state_d;
  logic [AW-2:0]       clr_idx_q, clr_idx_d;
  logic [2*WIDTH-1:0]  ra_q, ra_d;
  logic [WIDTH-1:0]    rb_q, rb_d;

  logic [WIDTH-1:0]    mem_even [HALF];
  logic [WIDTH-1:0]    mem_odd  [HALF];

  logic                wr_en, clr_en;
  logic [AW-1:0]       d1, a1;
  logic                we_e, we_o;
  logic [AW-2:0]       addr_e, addr_o;
  logic [WIDTH-1:0]    dat_e, dat_o;
  logic [WIDTH-1:0]    raw_a0, raw_a1, raw_b;
  logic [WIDTH-1:0]    ra_lo, ra_hi, rb_v;

  assign wr_en  = reset && (state_q == S_READY) && write;
  assign clr_en = reset && (state_q == S_CLEAR) && (CLEAR_ON_RESET != 0);
  assign d1     = d + AW'(1);
  assign a1     = a + AW'(1);

  // Write-first: a read byte whose index matches a byte written this edge takes the write data.
  function automatic logic [WIDTH-1:0] fwd(input logic [AW-1:0] idx, input logic [WIDTH-1:0] raw);
    logic [WIDTH-1:0] v;
    v = raw;
    if (wr_en && idx == d)
      v = Rd[WIDTH-1:0];
    else if (wr_en && write_word && idx == d1)
      v = Rd[2*WIDTH-1:WIDTH];
    return v;
  endfunction

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    if (!reset) begin
      state_d   = S_CLEAR;
      clr_idx_d = '0;
    end else if (state_q == S_CLEAR) begin
      if (CLEAR_ON_RESET == 0) begin
        state_d = S_READY;
      end else begin
        clr_idx_d = clr_idx_q + (AW-1)'(1);
        if (clr_idx_q == '1) state_d = S_READY;
      end
    end
  end

  // Each byte of a write goes to the bank selected by its own index's LSB.
  always_comb begin
    we_e   = 1'b0;
    we_o   = 1'b0;
    addr_e = '0;
    addr_o = '0;
    dat_e  = '0;
    dat_o  = '0;
    if (clr_en) begin
      we_e   = 1'b1;
      we_o   = 1'b1;
      addr_e = clr_idx_q;
      addr_o = clr_idx_q;
    end else if (wr_en) begin
      if (!d[0]) begin
        we_e   = 1'b1;
        addr_e = d[AW-1:1];
        dat_e  = Rd[WIDTH-1:0];
        we_o   = write_word;
        addr_o = d[AW-1:1];
        dat_o  = Rd[2*WIDTH-1:WIDTH];
      end else begin
        we_o   = 1'b1;
        addr_o = d[AW-1:1];
        dat_o  = Rd[WIDTH-1:0];
        we_e   = write_word;
        addr_e = d1[AW-1:1];
        dat_e  = Rd[2*WIDTH-1:WIDTH];
      end
    end
  end

  assign raw_a0 = a[0]  ? mem_odd[a[AW-1:1]]  : mem_even[a[AW-1:1]];
  assign raw_a1 = a1[0] ? mem_odd[a1[AW-1:1]] : mem_even[a1[AW-1:1]];
  assign raw_b  = b[0]  ? mem_odd[b[AW-1:1]]  : mem_even[b[AW-1:1]];

  always_comb begin
    ra_lo = fwd(a, raw_a0);
    ra_hi = fwd(a1, raw_a1);
    rb_v  = fwd(b, raw_b);
    ra_d  = '0;
    rb_d  = '0;
    if (reset && state_q == S_READY) begin
      ra_d = a_word ? {ra_hi, ra_lo} : {{WIDTH{1'b0}}, ra_lo};
      rb_d = rb_v;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_CLEAR;
      clr_idx_q <= '0;
      ra_q      <= '0;
      rb_q      <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      ra_q      <= ra_d;
      rb_q      <= rb_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we_e) mem_even[addr_e] <= dat_e;
    if (we_o) mem_odd[addr_o]  <= dat_o;
  end

  assign ready = (state_q == S_READY);
  assign Ra    = ra_q;
  assign Rb    = rb_q;

endmodule

// File: tb/tb_regfile_banked.sv
// Scoreboard bench for regfile_banked: a flat-array register model predicts each
// edge's outputs; a negedge monitor pops and compares them.
module tb_regfile_banked;

  localparam int N = 32;
  localparam int W = 8;

  logic          clk;
  logic          reset;
  logic          ready;
  logic [4:0]    a;
  logic          a_word;
  logic [15:0]   Ra;
  logic [4:0]    b;
  logic [7:0]    Rb;
  logic          write;
  logic          write_word;
  logic [4:0]    d;
  logic [15:0]   Rd;

  regfile_banked #(.WIDTH(W), .NUM_REGS(N), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .reset(reset), .ready(ready),
    .a(a), .a_word(a_word), .Ra(Ra),
    .b(b), .Rb(Rb),
    .write(write), .write_word(write_word), .d(d), .Rd(Rd)
  );

  typedef struct {
    logic        rdy;
    logic [15:0] ra;
    logic [7:0]  rb;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  logic [7:0] R [N];
  bit         m_ready = 0;
  int         clr_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_chk++;
      if (ready !== e.rdy) begin
        n_fail++;
        $display("FAIL ready: got %0b expected %0b at %0t", ready, e.rdy, $time);
      end
      n_chk++;
      if (Ra !== e.ra) begin
        n_fail++;
        $display("FAIL Ra: got %h expected %h at %0t", Ra, e.ra, $time);
      end
      n_chk++;
      if (Rb !== e.rb) begin
        n_fail++;
        $display("FAIL Rb: got %h expected %h at %0t", Rb, e.rb, $time);
      end
    end
  end

  task automatic step(input logic rst, input logic [4:0] ia, input logic iaw,
                      input logic [4:0] ib, input logic iw, input logic iww,
                      input logic [4:0] id, input logic [15:0] ird);
    exp_t e;
    reset = rst; a = ia; a_word = iaw; b = ib;
    write = iw; write_word = iww; d = id; Rd = ird;
    @(posedge clk);
    e.ra = '0;
    e.rb = '0;
    if (!rst) begin
      m_ready = 0;
      clr_cnt = 0;
    end else if (!m_ready) begin
      R[2*clr_cnt]     = '0;
      R[2*clr_cnt + 1] = '0;
      clr_cnt++;
      if (clr_cnt == N/2) m_ready = 1;
    end else begin
      if (iw) begin
        R[int'(id)] = ird[7:0];
        if (iww) R[(int'(id) + 1) % N] = ird[15:8];
      end
      e.ra = iaw ? {R[(int'(ia) + 1) % N], R[int'(ia)]} : {8'h00, R[int'(ia)]};
      e.rb = R[int'(ib)];
    end
    e.rdy = m_ready;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input logic rst);
    step(rst, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 16'h0);
  endtask

  task automatic rand_step(input logic rst);
    logic [4:0] rd_i, ra_i, rb_i;
    rd_i = 5'($urandom_range(0, N-1));
    ra_i = ($urandom_range(0, 3) == 0) ? rd_i + 5'($urandom_range(0, 2)) - 5'd1 : 5'($urandom_range(0, N-1));
    rb_i = ($urandom_range(0, 3) == 0) ? rd_i + 5'($urandom_range(0, 1)) : 5'($urandom_range(0, N-1));
    step(rst, ra_i, 1'($urandom), rb_i, 1'($urandom), 1'($urandom), rd_i, 16'($urandom));
  endtask

  initial begin
    for (int i = 0; i < N; i++) R[i] = 8'($urandom);
    idle(1'b0);
    idle(1'b0);
    for (int i = 0; i < N/2; i++) rand_step(1'b1);

    // Clear sequence: R7 written, reset pulse, writes during clear dropped
    step(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 5'd7, 16'h005A);
    step(1'b1, 5'd7, 1'b0, 5'd7, 1'b0, 1'b0, 5'd0, 16'h0);
    idle(1'b0);
    for (int i = 0; i < N/2; i++)
      step(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b1, 5'(i), 16'hFFFF);
    for (int i = 0; i < N; i++)
      step(1'b1, 5'(i), 1'b1, 5'(i), 1'b0, 1'b0, 5'd0, 16'h0);

    // Same-edge forward
    step(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd5, 16'h00A7);
    // Unaligned word
    step(1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd3, 16'h1234);
    step(1'b1, 5'd3, 1'b1, 5'd3, 1'b0, 1'b0, 5'd0, 16'h0);
    step(1'b1, 5'd4, 1'b0, 5'd4, 1'b0, 1'b0, 5'd0, 16'h0);
    // Wrap
    step(1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd31, 16'hBEEF);
    step(1'b1, 5'd31, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 16'h0);
    // Partial-overlap forward
    step(1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd10, 16'h2211);
    step(1'b1, 5'd10, 1'b1, 5'd11, 1'b1, 1'b0, 5'd11, 16'h0099);
    step(1'b1, 5'd10, 1'b1, 5'd11, 1'b0, 1'b0, 5'd0, 16'h0);

    for (int i = 0; i < 400; i++) rand_step(1'b1);

    // Reset mid-clear
    idle(1'b0);
    for (int i = 0; i < 8; i++) rand_step(1'b1);
    idle(1'b0);
    for (int i = 0; i < N/2; i++) rand_step(1'b1);
    for (int i = 0; i < 40; i++) rand_step(1'b1);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
